// File: rtl/code_load_sequencer_pkg.sv
// Shared definitions for the code-load sequencer: code word layout, FSM state
// encoding and a constant clog2 helper used to size address and pointer fields.
// No ports; imported by the interface, the code-word FIFO and the top.
package code_load_sequencer_pkg;

  localparam int CODE_DATA_WIDTH = 64;

  // Sequencer states (legacy-compatible constants rather than an enum)
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef struct packed {
    logic [31:0] high;
    logic [31:0] low;
  } code_word_t;

  // Ceiling log2, never less than 1 so that a depth of 1 still gets a field
  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    if (width == 0) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/code_load_sequencer_if.sv
// Instruction-memory code write port between the sequencer and parallel_cores.
// Ports: inst_wr_en (strobe), inst_wr_addr (ADDR_W bits), inst_wr_data (64 bits).
// master = sequencer (drives the write), slave = cores (receive the write).
interface code_load_sequencer_if #(
  parameter int ADDR_W = 9
);
  import code_load_sequencer_pkg::*;

  logic                       inst_wr_en;
  logic [ADDR_W-1:0]          inst_wr_addr;
  logic [CODE_DATA_WIDTH-1:0] inst_wr_data;

  modport master (output inst_wr_en, output inst_wr_addr, output inst_wr_data);
  modport slave  (input  inst_wr_en, input  inst_wr_addr, input  inst_wr_data);

endinterface

// File: rtl/code_load_sequencer_fifo.sv
// Code-word staging FIFO: synchronous, WIDTH x DEPTH (DEPTH a power of 2), show-ahead read.
// Ports: push/push_data write side, pop/pop_data read side, full/empty flags.
// A push while full is taken only together with a pop; a pop while empty is ignored.
module code_load_sequencer_fifo
  import code_load_sequencer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr_q;
  logic [PW:0]      rptr_q;
  logic             push_en;
  logic             pop_en;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign pop_en   = pop & ~empty;
  assign push_en  = push & (~full | pop_en);
  assign pop_data = mem[rptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/code_load_sequencer.sv
// Sequences instruction-memory reloads: assembles 64-bit words from low/high strobes,
// closes rdy_for_sn while code changes, drains in-flight work, writes words to the cores,
// and counts packets dropped while the gate is closed. Optional macro: CODE_LOAD_CHECKSUM_EN
// adds code_checksum (XOR of written words' halves, cleared at load start).
// Ports: register strobes/values in, snoop beat qualifiers in, cores_idle/rdy_for_sn_core in,
// rdy_for_sn out, code write port (interface master), busy/load_err/drop count out.
module code_load_sequencer
  import code_load_sequencer_pkg::*;
#(
  parameter int INST_MEM_DEPTH = 512,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               inst_low_value,
  input  logic                      inst_low_strobe,
  input  logic [31:0]               inst_high_value,
  input  logic                      inst_high_strobe,
  input  logic                      control_start,
  input  logic                      control_strobe,
  input  logic                      status_strobe,
  input  logic                      sn_TVALID,
  input  logic                      sn_TREADY,
  input  logic                      sn_TLAST,
  input  logic                      cores_idle,
  input  logic                      rdy_for_sn_core,
  output logic                      rdy_for_sn,
  code_load_sequencer_if.master     code_wr,
  output logic                      busy,
  output logic                      load_err,
`ifdef CODE_LOAD_CHECKSUM_EN
  output logic [31:0]               code_checksum,
`endif
  output logic [DROP_CNT_WIDTH-1:0] status_num_packets_dropped
);

  localparam int CODE_ADDR_WIDTH = clog2(INST_MEM_DEPTH);
  localparam logic [CODE_ADDR_WIDTH-1:0] LAST_ADDR = CODE_ADDR_WIDTH'(INST_MEM_DEPTH - 1);
  localparam logic [DROP_CNT_WIDTH-1:0]  DROP_ONE  = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                 state_q;
  logic                       commit_pend_q;
  logic                       in_pkt_q;
  logic                       mem_full_q;
  logic [31:0]                low_q;
  logic [CODE_ADDR_WIDTH-1:0] addr_q;
  logic [CODE_ADDR_WIDTH-1:0] wr_addr_q;
  logic [CODE_DATA_WIDTH-1:0] wr_data_q;
  logic                       wr_en_q;
  logic                       load_err_q;
  logic [DROP_CNT_WIDTH-1:0]  drop_cnt_q;

  code_word_t push_word;
  code_word_t pop_word;
  logic       fifo_full;
  logic       fifo_empty;
  logic       start_stb;
  logic       commit_stb;
  logic       run_start;
  logic       push_window;
  logic       push_ok;
  logic       push_drop;
  logic       pop;
  logic       pop_write;
  logic       pop_discard;
  logic       sn_beat;
  logic       first_beat_drop;

  assign start_stb   = control_strobe & control_start;
  assign commit_stb  = control_strobe & ~control_start;
  assign run_start   = start_stb & (state_q == ST_RUN);
  assign rdy_for_sn  = rdy_for_sn_core & (state_q == ST_RUN);
  assign busy        = (state_q != ST_RUN);

  assign pop         = ((state_q == ST_LOAD) | (state_q == ST_COMMIT)) & ~fifo_empty;
  assign push_window = (state_q == ST_DRAIN) | (state_q == ST_LOAD);
  assign push_ok     = inst_high_strobe & push_window & (~fifo_full | pop);
  assign push_drop   = inst_high_strobe & ~push_ok;
  // Once the last address has been written, further words have nowhere to go
  assign pop_write   = pop & ~mem_full_q;
  assign pop_discard = pop & mem_full_q;

  assign sn_beat         = sn_TVALID & sn_TREADY;
  assign first_beat_drop = sn_beat & ~in_pkt_q & ~rdy_for_sn;

  // A low strobe coinciding with the high strobe supplies the fresh low half
  always_comb begin
    push_word      = '0;
    push_word.high = inst_high_value;
    push_word.low  = inst_low_strobe ? inst_low_value : low_q;
  end

  code_load_sequencer_fifo #(
    .WIDTH (CODE_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Control FSM. A commit seen while draining is held until LOAD is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      commit_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          commit_pend_q <= 1'b0;
          if (start_stb) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (commit_stb) commit_pend_q <= 1'b1;
          if (cores_idle && !in_pkt_q) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (commit_stb || commit_pend_q) begin
            state_q       <= ST_COMMIT;
            commit_pend_q <= 1'b0;
          end
        end
        default: begin
          // COMMIT: finish once nothing is queued and the last write has gone out
          if (fifo_empty && !wr_en_q) state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Word assembly, packet tracking, address generation and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q      <= '0;
      in_pkt_q   <= 1'b0;
      addr_q     <= '0;
      mem_full_q <= 1'b0;
      load_err_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (inst_low_strobe) low_q <= inst_low_value;
      if (sn_beat) in_pkt_q <= ~sn_TLAST;

      if (run_start) begin
        addr_q     <= '0;
        mem_full_q <= 1'b0;
        load_err_q <= 1'b0;
      end else if (pop_write) begin
        if (addr_q == LAST_ADDR) mem_full_q <= 1'b1;
        else                     addr_q     <= addr_q + 1'b1;
      end

      // Writing the final slot also flags: the memory cannot take anything further
      if (push_drop || pop_discard || (pop_write && (addr_q == LAST_ADDR)))
        load_err_q <= 1'b1;

      wr_en_q <= pop_write;
      if (pop_write) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pop_word;
      end
    end
  end

  // Dropped-packet counter: saturating, cleared by a status read; a drop in the
  // same cycle as the read leaves a count of one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (status_strobe) begin
      drop_cnt_q <= first_beat_drop ? DROP_ONE : '0;
    end else if (first_beat_drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

`ifdef CODE_LOAD_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (run_start) begin
      checksum_q <= '0;
    end else if (pop_write) begin
      checksum_q <= checksum_q ^ pop_word.high ^ pop_word.low;
    end
  end

  assign code_checksum = checksum_q;
`endif

  assign code_wr.inst_wr_en   = wr_en_q;
  assign code_wr.inst_wr_addr = wr_addr_q;
  assign code_wr.inst_wr_data = wr_data_q;
  assign load_err             = load_err_q;
  assign status_num_packets_dropped = drop_cnt_q;

endmodule

// File: tb/tb_code_load_sequencer.sv
// Directed/randomized bench for code_load_sequencer with a behavioural reference:
// accepted words are queued; the expected write stream is the first INST_MEM_DEPTH of them
// at addresses 0.., and drops are counted per packet at the packet level.
module tb_code_load_sequencer;
  import code_load_sequencer_pkg::*;

  localparam int MEM_DEPTH = 16;
  localparam int FDEPTH    = 8;
  localparam int DCW       = 4;
  localparam int AW        = clog2(MEM_DEPTH);
  localparam int DROP_MAX  = (1 << DCW) - 1;

  logic           clk;
  logic           rst_n;
  logic [31:0]    inst_low_value;
  logic           inst_low_strobe;
  logic [31:0]    inst_high_value;
  logic           inst_high_strobe;
  logic           control_start;
  logic           control_strobe;
  logic           status_strobe;
  logic           sn_TVALID;
  logic           sn_TREADY;
  logic           sn_TLAST;
  logic           cores_idle;
  logic           rdy_for_sn_core;
  logic           rdy_for_sn;
  logic           busy;
  logic           load_err;
  logic [DCW-1:0] drops;
`ifdef CODE_LOAD_CHECKSUM_EN
  logic [31:0]    code_checksum;
`endif

  code_load_sequencer_if #(.ADDR_W(AW)) code_wr();

  code_load_sequencer #(
    .INST_MEM_DEPTH (MEM_DEPTH),
    .FIFO_DEPTH     (FDEPTH),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_low_value   (inst_low_value),
    .inst_low_strobe  (inst_low_strobe),
    .inst_high_value  (inst_high_value),
    .inst_high_strobe (inst_high_strobe),
    .control_start    (control_start),
    .control_strobe   (control_strobe),
    .status_strobe    (status_strobe),
    .sn_TVALID        (sn_TVALID),
    .sn_TREADY        (sn_TREADY),
    .sn_TLAST         (sn_TLAST),
    .cores_idle       (cores_idle),
    .rdy_for_sn_core  (rdy_for_sn_core),
    .rdy_for_sn       (rdy_for_sn),
    .code_wr          (code_wr),
    .busy             (busy),
    .load_err         (load_err),
`ifdef CODE_LOAD_CHECKSUM_EN
    .code_checksum    (code_checksum),
`endif
    .status_num_packets_dropped (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] acc[$];        // words the sequencer should have accepted this load
  int          m_drops = 0;   // expected dropped-packet count

  // Observed write stream
  logic [AW-1:0] log_addr[$];
  logic [63:0]   log_data[$];

  always @(negedge clk) begin
    if (rst_n && code_wr.inst_wr_en) begin
      log_addr.push_back(code_wr.inst_wr_addr);
      log_data.push_back(code_wr.inst_wr_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] lo, input logic [31:0] hi,
                           input bit same_cycle, input bit accept);
    inst_low_value  = lo;
    inst_low_strobe = 1'b1;
    if (!same_cycle) begin
      tick();
      inst_low_strobe = 1'b0;
      inst_low_value  = $urandom;   // latched low must be used, not the bus
    end
    inst_high_value  = hi;
    inst_high_strobe = 1'b1;
    tick();
    inst_high_strobe = 1'b0;
    inst_low_strobe  = 1'b0;
    if (accept) acc.push_back({hi, lo});
  endtask

  task automatic control(input bit start);
    control_start  = start;
    control_strobe = 1'b1;
    tick();
    control_strobe = 1'b0;
    control_start  = 1'b0;
  endtask

  // One packet of len beats with random stall cycles; gate_closed is the bench's own
  // view of whether rdy_for_sn is low while the packet starts
  task automatic send_pkt(input int len, input bit clr_first, input bit gate_closed);
    for (int b = 0; b < len; b++) begin
      sn_TVALID = 1'b1;
      sn_TREADY = 1'b0;
      sn_TLAST  = (b == len - 1);
      repeat ($urandom_range(0, 1)) tick();
      if (b == 0) begin
        if (clr_first)                           m_drops = gate_closed ? 1 : 0;
        else if (gate_closed && m_drops < DROP_MAX) m_drops++;
        status_strobe = clr_first;
      end
      sn_TREADY = 1'b1;
      tick();
      sn_TREADY     = 1'b0;
      status_strobe = 1'b0;
    end
    sn_TVALID = 1'b0;
    sn_TLAST  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  // Expected writes: accepted words in order, addresses from 0, capped by memory depth
  task automatic finish_load(input string tag, input bit chk_sum);
    logic [63:0] exp_w[$];
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < acc.size() && i < MEM_DEPTH; i++) begin
      exp_w.push_back(acc[i]);
      sum = sum ^ acc[i][63:32] ^ acc[i][31:0];
    end
    check({tag, "_count"}, 64'(log_data.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < log_data.size(); i++) begin
      check({tag, "_addr"}, 64'(log_addr[i]), 64'(i));
      check({tag, "_data"}, log_data[i], exp_w[i]);
    end
`ifdef CODE_LOAD_CHECKSUM_EN
    if (chk_sum) check({tag, "_checksum"}, 64'(code_checksum), 64'(sum));
`else
    if (chk_sum) sum = '0;
`endif
    acc.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    inst_low_value = '0;  inst_low_strobe = 1'b0;
    inst_high_value = '0; inst_high_strobe = 1'b0;
    control_start = 1'b0; control_strobe = 1'b0; status_strobe = 1'b0;
    sn_TVALID = 1'b0; sn_TREADY = 1'b0; sn_TLAST = 1'b0;
    cores_idle = 1'b1; rdy_for_sn_core = 1'b1;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_en", 64'(code_wr.inst_wr_en), 64'(0));
    check("rst_load_err", 64'(load_err), 64'(0));
    check("rst_drops", 64'(drops), 64'(0));
    check("rst_rdy_pass1", 64'(rdy_for_sn), 64'(1));
    rdy_for_sn_core = 1'b0;
    #1;
    check("rst_rdy_pass0", 64'(rdy_for_sn), 64'(0));
    rdy_for_sn_core = 1'b1;
    rst_n = 1'b1;
    tick();

    // Basic load of three words, with first-write latency measured
    control(1'b1);
    check("start_busy", 64'(busy), 64'(1));
    check("start_gate", 64'(rdy_for_sn), 64'(0));
    tick();
    push_word(32'h1, 32'hA, 1'b0, 1'b1);
    check("lat_t1_no_write", 64'(code_wr.inst_wr_en), 64'(0));
    tick();
    check("lat_t2_write", 64'(code_wr.inst_wr_en), 64'(1));
    check("lat_t2_addr", 64'(code_wr.inst_wr_addr), 64'(0));
    check("lat_t2_data", code_wr.inst_wr_data, 64'h0000000A_00000001);
    push_word(32'h2, 32'hB, 1'($urandom_range(0, 1)), 1'b1);
    push_word(32'h3, 32'hC, 1'($urandom_range(0, 1)), 1'b1);
    control(1'b0);
    wait_idle("basic_idle");
    finish_load("basic", 1'b1);
    check("basic_err", 64'(load_err), 64'(0));
    check("basic_gate_open", 64'(rdy_for_sn), 64'(1));

    // A push outside a load is discarded and flagged
    push_word($urandom, $urandom, 1'b1, 1'b0);
    repeat (3) tick();
    check("run_push_err", 64'(load_err), 64'(1));
    finish_load("run_push", 1'b0);

    // Start while a packet is open: hold in DRAIN until TLAST and cores_idle
    sn_TVALID = 1'b1; sn_TREADY = 1'b1; sn_TLAST = 1'b0;
    tick();
    sn_TVALID = 1'b0; sn_TREADY = 1'b0;
    control(1'b1);
    check("drain_err_cleared", 64'(load_err), 64'(0));
    begin
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push_word($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    repeat (5) tick();
    check("drain_hold_pkt", 64'(log_data.size()), 64'(0));
    cores_idle = 1'b0;
    sn_TVALID = 1'b1; sn_TREADY = 1'b1; sn_TLAST = 1'b1;
    tick();
    sn_TVALID = 1'b0; sn_TREADY = 1'b0; sn_TLAST = 1'b0;
    repeat (4) tick();
    check("drain_hold_idle", 64'(log_data.size()), 64'(0));
    control(1'b0);  // commit seen while still draining
    cores_idle = 1'b1;
    wait_idle("drain_idle");
    finish_load("drain", 1'b1);
    check("drain_no_drops", 64'(drops), 64'(m_drops));

    // Dropped-packet counting with the gate closed
    rdy_for_sn_core = 1'b0;
    #1;
    check("gate_closed", 64'(rdy_for_sn), 64'(0));
    for (int i = 0; i < 5; i++) send_pkt($urandom_range(1, 3), 1'b0, 1'b1);
    check("drops_five", 64'(drops), 64'(m_drops));
    check("drops_five_const", 64'(drops), 64'(5));
    send_pkt($urandom_range(1, 3), 1'b1, 1'b1);
    check("drops_clear_and_inc", 64'(drops), 64'(1));
    rdy_for_sn_core = 1'b1;
    send_pkt(2, 1'b0, 1'b0);
    check("drops_gate_open", 64'(drops), 64'(m_drops));
    status_strobe = 1'b1;
    tick();
    status_strobe = 1'b0;
    m_drops = 0;
    check("drops_cleared", 64'(drops), 64'(0));
    rdy_for_sn_core = 1'b0;
    for (int i = 0; i < DROP_MAX + 3; i++) send_pkt(1, 1'b0, 1'b1);
    check("drops_saturate", 64'(drops), 64'(m_drops));
    rdy_for_sn_core = 1'b1;
    send_pkt(1, 1'b1, 1'b0);
    check("drops_read_clear", 64'(drops), 64'(0));

    // Load more words than the memory holds
    control(1'b1);
    for (int i = 0; i < MEM_DEPTH + 4; i++)
      push_word($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    control(1'b0);
    wait_idle("wrap_idle");
    finish_load("wrap", 1'b1);
    check("wrap_err", 64'(load_err), 64'(1));

    // Overflow: nothing pops while draining, so the ninth word is lost
    cores_idle = 1'b0;
    control(1'b1);
    check("ovf_err_cleared", 64'(load_err), 64'(0));
    for (int i = 0; i < FDEPTH; i++)
      push_word($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    check("ovf_full_no_err", 64'(load_err), 64'(0));
    push_word($urandom, $urandom, 1'b1, 1'b0);
    check("ovf_err", 64'(load_err), 64'(1));
    cores_idle = 1'b1;
    control(1'b0);
    wait_idle("ovf_idle");
    finish_load("ovf", 1'b1);

    // Asynchronous reset in the middle of a load
    cores_idle = 1'b0;
    control(1'b1);
    push_word($urandom, $urandom, 1'b0, 1'b0);
    push_word($urandom, $urandom, 1'b1, 1'b0);
    send_pkt(1, 1'b0, 1'b1);
    check("mid_drops", 64'(drops), 64'(m_drops));
    cores_idle = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_drops = 0;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_wr_en", 64'(code_wr.inst_wr_en), 64'(0));
    check("arst_drops", 64'(drops), 64'(m_drops));
    check("arst_gate", 64'(rdy_for_sn), 64'(1));
    acc.delete();
    log_addr.delete();
    log_data.delete();
    tick();
    rst_n = 1'b1;
    tick();
    control(1'b1);
    control(1'b0);
    wait_idle("flush_idle");
    finish_load("flushed", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
